wb_test_slave: RTL and testbench

WB_TEST_SLAVE -- requirements
Module: wb_test_slave

---
 rtl/wb_test_slave.sv | 152 +++++++++++++++
 tb/tb_wb_test_slave.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_test_slave.sv
// Wishbone test slave: 15 r/w words plus a read-only transfer counter,
// with programmable wait states and an address-window error response.
module wb_test_slave #(
    parameter logic [31:0] BASE        = 32'h9900_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_next;
    logic [31:0] r_mem [15];
    logic [15:0] r_cnt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_req;
    logic        w_term_entry;
    logic        w_hit;
    logic [3:0]  w_idx;
    logic [31:0] w_mask;
    logic [31:0] w_rword;
    logic        w_unused;

    assign w_req        = wb_stb_i & wb_cyc_i;
    assign w_hit        = (wb_adr_i[31:6] == BASE[31:6]);
    assign w_idx        = wb_adr_i[5:2];
    assign w_term_entry = (w_next == ST_TERM) && (r_state != ST_TERM);
    assign w_mask       = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                           {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_unused     = ^wb_adr_i[1:0];

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;

    // Read mux: word 15 is the zero-extended transfer counter.
    always_comb begin
        w_rword = {16'h0000, r_cnt};
        for (int i = 0; i < 15; i++) begin
            if (w_idx == 4'(i)) begin
                w_rword = r_mem[i];
            end
        end
    end

    // Next-state and wait-counter logic; an abort in WAIT wins over expiry.
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_next = ST_TERM;
                    end else begin
                        w_next      = ST_WAIT;
                        w_wcnt_next = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_next      = ST_IDLE;
                    w_wcnt_next = 4'd0;
                end else if (r_wcnt == 4'd0) begin
                    w_next = ST_TERM;
                end else begin
                    w_wcnt_next = r_wcnt - 4'd1;
                end
            end
            ST_TERM:    w_next = ST_RECOVER;
            ST_RECOVER: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
        end
    end

    // Termination pulses, read data and transfer counter, all set on TERM entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'h0;
            r_cnt <= 16'h0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'h0;
            if (w_term_entry) begin
                if (w_hit) begin
                    r_ack <= 1'b1;
                    r_cnt <= r_cnt + 16'd1;
                    if (!wb_we_i) begin
                        r_dat <= w_rword & w_mask;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Byte-lane write into words 0..14; word 15 writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (w_term_entry && w_hit && wb_we_i && (w_idx == 4'(i))) begin
                    r_mem[i] <= (r_mem[i] & ~w_mask) | (wb_dat_i & w_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_test_slave.sv
// Directed testbench for wb_test_slave: one instance with two wait
// states and one with none, checked against hand-computed values.
module tb_wb_test_slave;

    localparam logic [31:0] BASE = 32'h9900_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dati, dato;
    logic        we, stb, cyc, ack, err;
    logic [3:0]  sel;
    logic [31:0] adr0, dati0, dato0;
    logic        we0, stb0, cyc0, ack0, err0;
    logic [3:0]  sel0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0;

    wb_test_slave #(.BASE(BASE), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(adr), .wb_dat_i(dati), .wb_dat_o(dato),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_sel_i(sel), .wb_ack_o(ack), .wb_err_o(err)
    );

    wb_test_slave #(.BASE(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(adr0), .wb_dat_i(dati0), .wb_dat_o(dato0),
        .wb_we_i(we0), .wb_stb_i(stb0), .wb_cyc_i(cyc0),
        .wb_sel_i(sel0), .wb_ack_o(ack0), .wb_err_o(err0)
    );

    always #5 clk = ~clk;

    function automatic logic get_ack(input bit d0);
        return d0 ? ack0 : ack;
    endfunction

    function automatic logic get_err(input bit d0);
        return d0 ? err0 : err;
    endfunction

    function automatic logic [31:0] get_dat(input bit d0);
        return d0 ? dato0 : dato;
    endfunction

    task automatic drive(input bit d0, input bit c, input bit w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (d0) begin
            cyc0 = c; stb0 = c; we0 = w; adr0 = a; dati0 = d; sel0 = s;
        end else begin
            cyc = c; stb = c; we = w; adr = a; dati = d; sel = s;
        end
    endtask

    // One full transfer; returns edges from request (request edge = 1)
    // to the termination, and whether the pulse was one cycle wide.
    task automatic xfer(input bit d0, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s,
                        output logic [31:0] rd, output bit ak,
                        output bit er, output int ne, output bit p1);
        @(negedge clk);
        drive(d0, 1'b1, w, a, d, s);
        rd = 32'h0; ak = 1'b0; er = 1'b0; ne = 0; p1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ne++;
            if (get_ack(d0) || get_err(d0)) begin
                ak = get_ack(d0);
                er = get_err(d0);
                rd = get_dat(d0);
                break;
            end
        end
        drive(d0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        p1 = !(get_ack(d0) || get_err(d0));
        @(posedge clk); #1;
        if (!d0 && a[31:6] == BASE[31:6]) exp_cnt++;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #3;
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_cnt = 16'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit ak, er, p1; int ne;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_chk++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_chk++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_chk++;
        if (dato !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", dato); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_cnt = 16'h0;
        xfer(1'b0, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (ak !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_word2: ack %b data %h expected ack 1 data 0", ak, rd);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; bit ak, er, p1; int ne;
        xfer(1'b0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (ak !== 1'b1 || er !== 1'b0) begin
            n_fail++; $display("FAIL wr_term: ack %b err %b expected ack 1 err 0", ak, er);
        end
        n_chk++;
        if (ne !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d edges expected 3", ne); end
        n_chk++;
        if (p1 !== 1'b1) begin n_fail++; $display("FAIL wr_pulse: ack wider than 1 cycle"); end
        n_chk++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_dat_o: got %h expected 0", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        n_chk++;
        if (ne !== 3 || p1 !== 1'b1) begin
            n_fail++; $display("FAIL rd_timing: edges %0d pulse_ok %b expected 3 1", ne, p1);
        end
        n_chk++;
        if (dato !== 32'h0) begin n_fail++; $display("FAIL dat_idle: got %h expected 0", dato); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; bit ak, er, p1; int ne;
        xfer(1'b0, 1'b1, BASE + 32'h4, 32'h0000_00AA, 4'b0001, rd, ak, er, ne, p1);
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL lane_write: got %h expected deadbeaa", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'b1100, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hDEAD_0000) begin n_fail++; $display("FAIL lane_read: got %h expected dead0000", rd); end
        xfer(1'b0, 1'b1, BASE + 32'h4, 32'h1234_5678, 4'h0, rd, ak, er, ne, p1);
        n_chk++;
        if (ak !== 1'b1) begin n_fail++; $display("FAIL sel0_ack: got %b expected 1", ak); end
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL sel0_nochange: got %h expected deadbeaa", rd); end
    endtask

    task automatic test_err();
        logic [31:0] rd; bit ak, er, p1; int ne;
        logic [15:0] c;
        c = exp_cnt;
        xfer(1'b0, 1'b1, 32'h9A00_0004, 32'h1234_5678, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (er !== 1'b1 || ak !== 1'b0) begin
            n_fail++; $display("FAIL err_term: ack %b err %b expected ack 0 err 1", ak, er);
        end
        n_chk++;
        if (p1 !== 1'b1 || ne !== 3) begin
            n_fail++; $display("FAIL err_pulse: edges %0d pulse_ok %b expected 3 1", ne, p1);
        end
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL err_mem: got %h expected deadbeaa", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== {16'h0, c + 16'd1}) begin
            n_fail++; $display("FAIL err_count: got %h expected %h", rd, {16'h0, c + 16'd1});
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; bit ak, er, p1; int ne;
        int nt;
        xfer(1'b0, 1'b1, BASE + 32'h8, 32'h1111_1111, 4'hF, rd, ak, er, ne, p1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'h2222_2222, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0;
        nt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack || err) nt++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_chk++;
        if (nt !== 0) begin n_fail++; $display("FAIL abort_term: got %0d terminations expected 0", nt); end
        xfer(1'b0, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL abort_mem: got %h expected 11111111", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit ak, er, p1; int ne;
        bit seen;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack) begin seen = 1'b1; break; end
        end
        n_chk++;
        if (seen !== 1'b1 || dato !== 32'hDEAD_BEAA) begin
            n_fail++; $display("FAIL midterm_ack: seen %b data %h expected 1 deadbeaa", seen, dato);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (ack !== 1'b0 || dato !== 32'h0) begin
            n_fail++; $display("FAIL midterm_reset: ack %b data %h expected 0 0", ack, dato);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, BASE + 32'hC, 32'h3333_3333, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ack !== 1'b0 || err !== 1'b0 || dato !== 32'h0) begin
            n_fail++; $display("FAIL midwait_reset: ack %b err %b data %h expected 0 0 0", ack, err, dato);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_cnt = 16'h0;
        xfer(1'b0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (ak !== 1'b1 || ne !== 3 || rd !== 32'h0) begin
            n_fail++; $display("FAIL first_edge: ack %b edges %0d data %h expected 1 3 0", ak, ne, rd);
        end
        xfer(1'b0, 1'b0, BASE + 32'hC, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL midwait_mem: got %h expected 0", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_clear: got %h expected 0", rd); end
    endtask

    task automatic test_counter();
        logic [31:0] rd; bit ak, er, p1; int ne;
        reset_pulse();
        xfer(1'b0, 1'b1, BASE + 32'h10, 32'h4, 4'hF, rd, ak, er, ne, p1);
        xfer(1'b0, 1'b1, BASE + 32'h14, 32'h5, 4'hF, rd, ak, er, ne, p1);
        xfer(1'b0, 1'b1, BASE + 32'h18, 32'h6, 4'hF, rd, ak, er, ne, p1);
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'd3) begin n_fail++; $display("FAIL cnt_3: got %h expected 3", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'd4) begin n_fail++; $display("FAIL cnt_4: got %h expected 4", rd); end
        xfer(1'b0, 1'b1, BASE + 32'h3C, 32'h1234_5678, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (ak !== 1'b1) begin n_fail++; $display("FAIL w15_ack: got %b expected 1", ak); end
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'd6) begin n_fail++; $display("FAIL w15_ro: got %h expected 6", rd); end
        @(negedge clk);
        force dut.r_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_cnt;
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'h0000_FFFF) begin n_fail++; $display("FAIL cnt_ffff: got %h expected 0000ffff", rd); end
        xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h expected 0", rd); end
    endtask

    task automatic test_hold_past_ack();
        logic [31:0] rd; bit ak, er, p1; int ne;
        int nacks;
        bit first;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, BASE + 32'h14, 32'hA5A5_A5A5, 4'hF);
        nacks = 0;
        first = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack0) nacks++;
            if (i == 0) first = ack0;
            if (i == 1) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        n_chk++;
        if (first !== 1'b1) begin n_fail++; $display("FAIL ws0_latency: ack after 1 edge got %b expected 1", first); end
        n_chk++;
        if (nacks !== 1) begin n_fail++; $display("FAIL ws0_single_ack: got %0d acks expected 1", nacks); end
        xfer(1'b1, 1'b0, BASE + 32'h3C, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'd1) begin n_fail++; $display("FAIL ws0_count: got %h expected 1", rd); end
        xfer(1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'hF, rd, ak, er, ne, p1);
        n_chk++;
        if (rd !== 32'hA5A5_A5A5 || ne !== 1) begin
            n_fail++; $display("FAIL ws0_read: data %h edges %0d expected a5a5a5a5 1", rd, ne);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_err();
        test_abort();
        test_reset_mid();
        test_counter();
        test_hold_past_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
